// File: rtl/dose_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dose_scheduler
// Purpose  : Matches the time-of-day bus against a programmable dose table and
//            runs a req/ack handshake to the dispenser, timing out missed doses.
//            Optional macro DOSE_MISS_COUNT_EN adds a saturating miss counter.
// Revision : 1.0  initial release
// ============================================================================
module dose_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int MISS_SECS = 60,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          sec_pulse,
  input  logic [4:0]    hours,
  input  logic [5:0]    minutes,
  input  logic [5:0]    seconds,
  input  logic          prog_we,
  input  logic [SW-1:0] prog_slot,
  input  logic          prog_en,
  input  logic [4:0]    prog_hour,
  input  logic [5:0]    prog_min,
  output logic          dispense_req,
  output logic [SW-1:0] dispense_slot,
  input  logic          dispense_ack,
  output logic          missed_dose,
  output logic          alarm,
  output logic [7:0]    missed_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [7:0] C_MISS  = 8'(MISS_SECS);

  logic [1:0]           state_q, state_d;
  logic                 tick_q;
  logic [NUM_SLOTS-1:0] en_q;
  logic [4:0]           hour_q [NUM_SLOTS];
  logic [5:0]           min_q  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] pend_q, pend_d, match_w;
  logic [SW-1:0]        slot_q, slot_d, grant_idx;
  logic                 grant_vld, grant_take;
  logic [7:0]           cnt_q, cnt_d;
  logic                 missed_q, missed_d;
  logic                 alarm_q;
  logic                 prog_hit;

  assign prog_hit = prog_we && (32'(prog_slot) < NUM_SLOTS);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        en_q[i]   <= 1'b0;
        hour_q[i] <= '0;
        min_q[i]  <= '0;
      end
    end else if (prog_hit) begin
      en_q[prog_slot]   <= prog_en;
      hour_q[prog_slot] <= prog_hour;
      min_q[prog_slot]  <= prog_min;
    end
  end

  // A slot already pending or currently being requested never re-arms.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_match
    assign match_w[i] = tick_q && (seconds == 6'd0) && en_q[i] &&
                        (hour_q[i] == hours) && (min_q[i] == minutes) &&
                        (hour_q[i] < 5'd24) && (min_q[i] < 6'd60) &&
                        !pend_q[i] &&
                        !((state_q == ST_REQ) && (slot_q == SW'(i)));
  end

  always_comb begin
    grant_vld = |pend_q;
    grant_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pend_q[i]) grant_idx = SW'(i);
    end
  end

  always_comb begin
    pend_d = pend_q | match_w;
    if (grant_take) pend_d[grant_idx] = 1'b0;
    if (prog_hit)   pend_d[prog_slot] = 1'b0;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      tick_q   <= 1'b0;
      pend_q   <= '0;
      slot_q   <= '0;
      cnt_q    <= '0;
      missed_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= sec_pulse;
      pend_q   <= pend_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
      alarm_q  <= (|pend_d) | (state_d == ST_REQ);
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    missed_d   = 1'b0;
    grant_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          grant_take = 1'b1;
          slot_d     = grant_idx;
          cnt_d      = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack outranks a timeout landing in the same cycle.
        if (dispense_ack) begin
          state_d = ST_DONE;
        end else if (tick_q) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == C_MISS) begin
            missed_d = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dispense_req  = (state_q == ST_REQ);
    dispense_slot = slot_q;
    missed_dose   = missed_q;
    alarm         = alarm_q;
  end

`ifdef DOSE_MISS_COUNT_EN
  logic [7:0] mcnt_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      mcnt_q <= '0;
    end else if (missed_d && (mcnt_q != 8'hFF)) begin
      mcnt_q <= mcnt_q + 8'd1;
    end
  end

  assign missed_count = mcnt_q;
`else
  assign missed_count = 8'h00;
`endif

endmodule
`default_nettype wire
